// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory controller.
// Turns load/store requests into req/ack bus transactions and stalls the pipeline until they finish.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        stall,
    output logic [31:0] mem_data_out,
    output logic        misalign_err,
    output logic        timeout_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;

    logic        req;
    logic        misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    // Request decode: alignment check and store lane placement.
    always_comb begin
        req        = mem_read_in | mem_write_in;
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wdata_new  = wdata_in;
        case (size_in)
            2'b00: begin
                be_new    = 4'b0001 << addr_in[1:0];
                wdata_new = {4{wdata_in[7:0]}};
            end
            2'b01: begin
                misaligned = addr_in[0];
                be_new     = addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_new  = {2{wdata_in[15:0]}};
            end
            default: begin
                misaligned = (addr_in[1:0] != 2'b00);
            end
        endcase
    end

    always_comb begin
        rd_byte = bus_rdata[{off_q, 3'b000} +: 8];
        rd_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (size_q)
            2'b00:   load_data = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
            2'b01:   load_data = {{16{rd_half[15] & ~uns_q}}, rd_half};
            default: load_data = bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        mem_data_d  = mem_data_q;
        misalign_d  = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (misaligned) begin
                        mem_data_d = '0;
                        misalign_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write_in;
                        bus_addr_d  = {addr_in[31:2], 2'b00};
                        bus_be_d    = be_new;
                        bus_wdata_d = mem_write_in ? wdata_new : '0;
                        size_d      = size_in;
                        uns_d       = unsigned_in;
                        off_d       = addr_in[1:0];
                        cnt_d       = '0;
                        state_d     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // An ack on the last allowed cycle still completes the access.
                if (bus_ack) begin
                    mem_data_d = bus_we_q ? '0 : load_data;
                    bus_req_d  = 1'b0;
                    state_d    = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_data_d = '0;
                    timeout_d  = 1'b1;
                    bus_req_d  = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                bus_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            mem_data_q  <= '0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            mem_data_q  <= mem_data_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
        end
    end

    // Stall is forced low while reset is held, even with a request pending.
    assign stall        = reset & (((state_q == S_IDLE) & req) | (state_q == S_WAIT));
    assign mem_data_out = mem_data_q;
    assign misalign_err = misalign_q;
    assign timeout_err  = timeout_q;
    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_be       = bus_be_q;
    assign bus_wdata    = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// accesses checked against a byte-level reference model.
module tb_mem_access_unit;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_in, mem_write_in, unsigned_in;
    logic [1:0]  size_in;
    logic [31:0] addr_in, wdata_in;
    logic        stall;
    logic [31:0] mem_data_out;
    logic        misalign_err, timeout_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .size_in(size_in), .unsigned_in(unsigned_in),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .stall(stall), .mem_data_out(mem_data_out),
        .misalign_err(misalign_err), .timeout_err(timeout_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    // Gather nb bytes starting at lane off, then extend.
    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                             input int off, input logic [31:0] rdata);
        int nb;
        longint unsigned v, w;
        nb = nbytes(size);
        v  = 0;
        w  = rdata;
        for (int i = 0; i < nb; i++) v += ((w >> (8 * (off + i))) & 255) << (8 * i);
        if (!uns && nb < 4 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] size, input int off);
        logic [3:0] be;
        be = '0;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + nbytes(size)) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        int nb;
        nb = nbytes(size);
        r  = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
        return r;
    endfunction

    // Runs one access; ack_at = index of the WAIT cycle that acks (-1 = never).
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int ack_at, input logic [31:0] rdata);
        int nb, off, exp_waits, waits, stalls;
        bit mis, timed_out, done, bus_bad;
        logic [31:0] exp_data;
        nb        = nbytes(size);
        off       = int'(addr % 4);
        mis       = (addr % nb) != 0;
        timed_out = !mis && !(ack_at >= 0 && ack_at < int'(TIMEOUT));
        exp_waits = mis ? 0 : timed_out ? int'(TIMEOUT) : ack_at + 1;
        exp_data  = (mis || wr || timed_out) ? 32'd0 : ref_load(size, uns, off, rdata);
        waits = 0; stalls = 0; done = 0; bus_bad = 0;

        mem_read_in = rd; mem_write_in = wr; size_in = size; unsigned_in = uns;
        addr_in = addr; wdata_in = wdata;
        #1;
        for (int c = 0; c < int'(TIMEOUT) + 8 && !done; c++) begin
            if (!stall) begin
                done = 1;
                n_checks++;
                if (mem_data_out !== exp_data)
                    $display("FAIL %s data: got %h want %h", name, mem_data_out, exp_data);
                else n_pass++;
                n_checks++;
                if (misalign_err !== mis)
                    $display("FAIL %s misalign_err: got %b want %b", name, misalign_err, mis);
                else n_pass++;
                n_checks++;
                if (timeout_err !== timed_out)
                    $display("FAIL %s timeout_err: got %b want %b", name, timeout_err, timed_out);
                else n_pass++;
                mem_read_in = 0; mem_write_in = 0; bus_ack = 0;
            end else begin
                stalls++;
                if (bus_req) begin
                    if (bus_we !== wr || bus_addr !== {addr[31:2], 2'b00} ||
                        bus_be !== ref_be(size, off) ||
                        (wr && bus_wdata !== ref_wdata(size, wdata))) begin
                        if (!bus_bad)
                            $display("FAIL %s bus fields: we=%b addr=%h be=%b wd=%h want we=%b addr=%h be=%b wd=%h",
                                     name, bus_we, bus_addr, bus_be, bus_wdata, wr,
                                     {addr[31:2], 2'b00}, ref_be(size, off), ref_wdata(size, wdata));
                        bus_bad = 1;
                    end
                    bus_ack   = (waits == ack_at);
                    bus_rdata = (waits == ack_at) ? rdata : $urandom;
                    waits++;
                end else begin
                    bus_ack   = 1'($urandom_range(0, 1));
                    bus_rdata = $urandom;
                end
            end
            @(posedge clk); #1;
        end
        bus_ack = 0;
        n_checks++;
        if (!done) $display("FAIL %s done: never reached (cycle budget expired)", name);
        else n_pass++;
        n_checks++;
        if (stalls != 1 + exp_waits)
            $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, 1 + exp_waits);
        else n_pass++;
        n_checks++;
        if (waits != exp_waits)
            $display("FAIL %s bus_req cycles: got %0d want %0d", name, waits, exp_waits);
        else n_pass++;
        n_checks++;
        if (bus_bad) $display("FAIL %s bus hold: got unstable/wrong fields want stable", name);
        else n_pass++;
        // Cycle after DONE: back in IDLE, pulses gone, data held.
        n_checks++;
        if (bus_req !== 0 || stall !== 0 || misalign_err !== 0 || timeout_err !== 0 ||
            mem_data_out !== exp_data)
            $display("FAIL %s post-done: got req=%b stall=%b me=%b te=%b data=%h want 0 0 0 0 %h",
                     name, bus_req, stall, misalign_err, timeout_err, mem_data_out, exp_data);
        else n_pass++;
        if (!done) begin
            reset = 0; #2; reset = 1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 0;
        mem_read_in = 0; mem_write_in = 0; size_in = 0; unsigned_in = 0;
        addr_in = 0; wdata_in = 0; bus_ack = 0; bus_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({stall, mem_data_out, misalign_err, timeout_err, bus_req, bus_we,
             bus_addr, bus_be, bus_wdata} !== '0)
            $display("FAIL reset outputs: got req=%b stall=%b data=%h addr=%h be=%b wd=%h want all 0",
                     bus_req, stall, mem_data_out, bus_addr, bus_be, bus_wdata);
        else n_pass++;
        reset = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_load();
        run_access("word_load", 1, 0, 2'b10, 0, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    endtask

    task automatic test_byte_load();
        run_access("byte_load_s", 1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 32'h80123456);
        run_access("byte_load_u", 1, 0, 2'b00, 1, 32'h103, 32'h0, 0, 32'h80123456);
        run_access("half_load_s", 1, 0, 2'b01, 0, 32'h102, 32'h0, 1, 32'h9ABC1234);
    endtask

    task automatic test_half_store();
        run_access("half_store", 0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 1, 32'h0);
        run_access("byte_store", 1, 1, 2'b00, 0, 32'h301, 32'h123456EF, 0, 32'h0);
    endtask

    task automatic test_misalign();
        run_access("misalign_word", 1, 0, 2'b10, 0, 32'h101, 32'h0, 0, 32'h11111111);
        run_access("misalign_half", 0, 1, 2'b01, 0, 32'h203, 32'hFFFF, 0, 32'h0);
    endtask

    task automatic test_timeout();
        run_access("timeout", 1, 0, 2'b10, 0, 32'h400, 32'h0, -1, 32'h0);
        run_access("ack_last_cycle", 1, 0, 2'b11, 0, 32'h404, 32'h0, TIMEOUT - 1, 32'hCAFEF00D);
    endtask

    task automatic test_reset_mid_wait();
        bit bad;
        mem_read_in = 1; mem_write_in = 0; size_in = 2'b10; unsigned_in = 0;
        addr_in = 32'h40; bus_ack = 0;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (bus_req !== 1) $display("FAIL mid_wait precondition bus_req: got %b want 1", bus_req);
        else n_pass++;
        reset = 0;
        #1;
        n_checks++;
        if (bus_req !== 0 || stall !== 0 || mem_data_out !== 0 || bus_addr !== 0 || bus_be !== 0)
            $display("FAIL mid_wait reset: got req=%b stall=%b data=%h addr=%h be=%b want 0",
                     bus_req, stall, mem_data_out, bus_addr, bus_be);
        else n_pass++;
        mem_read_in = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            bus_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (bus_req !== 0 || stall !== 0) bad = 1;
        end
        bus_ack = 0;
        n_checks++;
        if (bad) $display("FAIL post_reset idle: got bus activity want none");
        else n_pass++;
        run_access("after_reset", 1, 0, 2'b00, 1, 32'h41, 32'h0, 0, 32'h0000A500);
    endtask

    task automatic test_random();
        logic rd, wr;
        int ack_at;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            ack_at = int'($urandom_range(0, TIMEOUT + 2));
            if (ack_at >= int'(TIMEOUT)) ack_at = -1;
            run_access("random", rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       $urandom, $urandom, ack_at, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misalign();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
